// File: rtl/fft8_frame_sched_pkg.sv
// ============================================================================
// Module : fft8_frame_sched_pkg
// Shared state encoding and the 3-bit bit-reversal helper for the 8-point
// FFT frame scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fft8_frame_sched_pkg;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_UNLOAD  = 2'd3;

  typedef enum logic [1:0] {
    S_LOAD    = ST_LOAD,
    S_START   = ST_START,
    S_COMPUTE = ST_COMPUTE,
    S_UNLOAD  = ST_UNLOAD
  } state_e;

  localparam int CNT_W = 3;

  // Decimation-in-time input ordering for an 8-point transform
  function automatic logic [CNT_W-1:0] bitrev3(input logic [CNT_W-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft8_frame_sched.sv
// ============================================================================
// Module : fft8_frame_sched
// Sequences one 8-point frame through an external register file and FFT core:
// bit-reversed load, start/compute with watchdog, natural-order unload.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fft8_frame_sched
  import fft8_frame_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_data,
  output logic                 rf_sel,
  output logic                 rf_we,
  output logic [2:0]           rf_waddr,
  output logic [2*WIDTH-1:0]   rf_wdata,
  output logic [2:0]           rf_raddr,
  input  logic [2*WIDTH-1:0]   rf_rdata,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_last,
  output logic                 err_timeout
);

  localparam int                WD_W     = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WD_W-1:0]   wd_q;
  logic              err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_START;
              cnt_q   <= '0;
            end
          end
        end
        S_START: begin
          state_q <= S_COMPUTE;
          wd_q    <= '0;
        end
        S_COMPUTE: begin
          // A completion arriving on the final watchdog cycle still wins
          if (fft_done) begin
            state_q <= S_UNLOAD;
            cnt_q   <= '0;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_LOAD;
              cnt_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= S_LOAD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    rf_sel    = 1'b1;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_raddr  = '0;
    fft_start = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rf_we    = 1'b1;
          rf_waddr = bitrev3(cnt_q);
          rf_wdata = in_data;
        end
      end
      S_START: begin
        fft_start = 1'b1;
        rf_sel    = 1'b0;
      end
      S_COMPUTE: begin
        rf_sel = 1'b0;
      end
      S_UNLOAD: begin
        rf_raddr  = cnt_q;
        out_valid = 1'b1;
        out_last  = (cnt_q == LAST_IDX);
      end
      default: begin
        rf_sel = 1'b1;
      end
    endcase
  end

  assign out_data    = rf_rdata;
  assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fft8_frame_sched.sv
// ============================================================================
// Module : tb_fft8_frame_sched
// Directed bench with a frame-level reference model and register-file stub.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fft8_frame_sched;

  localparam int W  = 12;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*W-1:0]  in_data = '0;
  logic            rf_sel;
  logic            rf_we;
  logic [2:0]      rf_waddr;
  logic [2*W-1:0]  rf_wdata;
  logic [2:0]      rf_raddr;
  logic [2*W-1:0]  rf_rdata;
  logic            fft_start;
  logic            fft_done = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*W-1:0]  out_data;
  logic            out_last;
  logic            err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  fft8_frame_sched #(.N(8), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rf_sel(rf_sel), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .fft_start(fft_start), .fft_done(fft_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // External register file stub (core leaves data untouched)
  logic [2*W-1:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = '0;
  always @(posedge clk) if (rf_we) mem[rf_waddr] <= rf_wdata;
  assign rf_rdata = mem[rf_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  // Frame-level model: phase 0 load, 1 start, 2 compute, 3 unload
  int             m_phase = 0;
  int             m_idx   = 0;
  int             m_wd    = 0;
  logic           m_err   = 1'b0;
  logic [2*W-1:0] loaded [8];
  initial for (int i = 0; i < 8; i++) loaded[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_idx <= 0; m_wd <= 0; m_err <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             loaded[m_idx] <= in_data;
             if (m_idx == 7) begin m_phase <= 1; m_idx <= 0; end
             else m_idx <= m_idx + 1;
           end
        1: begin m_phase <= 2; m_wd <= 0; end
        2: if (fft_done) begin m_phase <= 3; m_idx <= 0; end
           else if (m_wd == TO - 1) begin m_err <= 1'b1; m_phase <= 0; m_idx <= 0; end
           else m_wd <= m_wd + 1;
        default: if (out_ready) begin
             if (m_idx == 7) begin m_phase <= 0; m_idx <= 0; end
             else m_idx <= m_idx + 1;
           end
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic e_we;
    e_we = (m_phase == 0) && in_valid;
    chk("in_ready",  32'(in_ready),  32'(m_phase == 0));
    chk("rf_sel",    32'(rf_sel),    32'(m_phase == 0 || m_phase == 3));
    chk("rf_we",     32'(rf_we),     32'(e_we));
    chk("rf_waddr",  32'(rf_waddr),  e_we ? 32'(brev(m_idx)) : 32'd0);
    chk("rf_wdata",  32'(rf_wdata),  e_we ? 32'(in_data) : 32'd0);
    chk("fft_start", 32'(fft_start), 32'(m_phase == 1));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 3));
    chk("out_last",  32'(out_last),  32'(m_phase == 3 && m_idx == 7));
    chk("rf_raddr",  32'(rf_raddr),  (m_phase == 3) ? 32'(m_idx) : 32'd0);
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    if (m_phase == 3) chk("out_data", 32'(out_data), 32'(loaded[brev(m_idx)]));
  end

  int         waddr_log[$];
  logic [3:0] xfer_log[$];
  always @(posedge clk) begin
    if (rf_we) waddr_log.push_back(int'(rf_waddr));
    if (out_valid && out_ready) xfer_log.push_back({out_last, rf_raddr});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_frame(input int base);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = {12'(base + k * 37), 12'(base * 3 + k)};
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_xfers(input string tag);
    chk({tag, "_xfer_count"}, 32'(xfer_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < xfer_log.size(); i++)
      chk({tag, "_xfer"}, 32'(xfer_log[i]), 32'({(i == 7), 3'(i)}));
  endtask

  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    step(); step();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    step();

    // Frame 1: waddr order, start latency, done after 14 cycles, free-flowing unload
    waddr_log.delete();
    load_frame(5);
    chk("start_after_last_accept", 32'(fft_start), 32'd1);
    chk("waddr_count", 32'(waddr_log.size()), 32'd8);
    begin
      int exp_w [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int i = 0; i < 8 && i < waddr_log.size(); i++)
        chk("waddr_seq", 32'(waddr_log[i]), 32'(exp_w[i]));
    end
    for (int i = 0; i < 14; i++) step();
    chk("compute_rf_sel", 32'(rf_sel), 32'd0);
    fft_done = 1'b1; step(); fft_done = 1'b0;
    chk("out_valid_after_done", 32'(out_valid), 32'd1);
    xfer_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) step();
    check_xfers("f1");

    // Frame 2: back-pressure pattern 1,0,0,1
    load_frame(200);
    for (int i = 0; i < 6; i++) step();
    fft_done = 1'b1; step(); fft_done = 1'b0;
    xfer_log.delete();
    for (int i = 0; i < 80 && out_valid; i++) begin
      out_ready = pat[i % 4];
      step();
    end
    out_ready = 1'b1;
    check_xfers("f2");

    // Frame 3: done coincides with the final watchdog cycle
    load_frame(77);
    step();
    for (int i = 0; i < 31; i++) step();
    fft_done = 1'b1; step(); fft_done = 1'b0;
    chk("prio_out_valid", 32'(out_valid), 32'd1);
    chk("prio_err", 32'(err_timeout), 32'd0);
    xfer_log.delete();
    for (int i = 0; i < 40 && out_valid; i++) step();
    check_xfers("f3");

    // Frame 4: no done, watchdog expires at compute cycle 32
    load_frame(1000);
    step();
    for (int i = 0; i < 31; i++) step();
    chk("to_err_before", 32'(err_timeout), 32'd0);
    chk("to_in_ready_before", 32'(in_ready), 32'd0);
    step();
    chk("to_err_after", 32'(err_timeout), 32'd1);
    chk("to_in_ready_after", 32'(in_ready), 32'd1);
    fft_done = 1'b1; step(); fft_done = 1'b0;
    chk("done_ignored_in_load", 32'(in_ready), 32'd1);

    // Partial frame while error set, then reset after 5 accepts
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = {12'(k + 9), 12'(k)};
      step();
    end
    chk("err_sticky_loading", 32'(err_timeout), 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err_clear", 32'(err_timeout), 32'd0);
    step();
    rst = 1'b0;
    waddr_log.delete();
    in_valid = 1'b1; in_data = 24'hABC123;
    step();
    in_valid = 1'b0;
    chk("post_rst_waddr_count", 32'(waddr_log.size()), 32'd1);
    if (waddr_log.size() > 0) chk("post_rst_waddr", 32'(waddr_log[0]), 32'd0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft8_frame_sched.md
FFT8_FRAME_SCHED -- requirements
Module: fft8_frame_sched

Interface
REQ-001 Parameter N, default 8: FFT points per frame; only 8 is supported.
REQ-002 Parameter WIDTH, default 12: bits per real/imag component.
REQ-003 Parameter TIMEOUT, default 32: maximum compute cycles to wait for fft_done.
REQ-004 Port clk, input, 1: clock, rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port in_valid / in_ready, input / output, 1 each: input sample handshake.
REQ-007 Port in_data, input, 2*WIDTH: sample {re[2W-1:W], im[W-1:0]}.
REQ-008 Port rf_sel, output, 1: 1 means the scheduler owns the register-file ports; 0 means the FFT core owns them.
REQ-009 Port rf_we, output, 1: register-file write enable.
REQ-010 Port rf_waddr, output, 3: register-file write address.
REQ-011 Port rf_wdata, output, 2*WIDTH: register-file write data.
REQ-012 Port rf_raddr, output, 3: register-file read address.
REQ-013 Port rf_rdata, input, 2*WIDTH: combinational read data at rf_raddr.
REQ-014 Port fft_start, output, 1: one-cycle start pulse to the FFT core controller.
REQ-015 Port fft_done, input, 1: one-cycle completion pulse from the core.
REQ-016 Port out_valid / out_ready, output / input, 1 each: output sample handshake.
REQ-017 Port out_data, output, 2*WIDTH: output sample (equals rf_rdata).
REQ-018 Port out_last, output, 1: marks the 8th output sample.
REQ-019 Port err_timeout, output, 1: sticky flag for a timed-out computation.

Function
REQ-020 States SHALL be LOAD, START, COMPUTE, UNLOAD; reset enters LOAD with cnt=0.
REQ-021 LOAD behaviour:
- in_ready=1, rf_sel=1.
- On in_valid&&in_ready: rf_we=1, rf_waddr=bitrev3(cnt), rf_wdata=in_data, cnt++.
- When the 8th sample is accepted (cnt==7): go to START, cnt=0.
REQ-022 rf_we SHALL be combinational (in_valid&&in_ready in LOAD); there is no write in any other state.
REQ-023 START SHALL last exactly one cycle:
- fft_start=1, rf_sel=0, in_ready=0.
- Next state COMPUTE, watchdog wd=0.
REQ-024 COMPUTE behaviour:
- rf_sel=0, in_ready=0, wd++ each cycle.
- fft_done=1 -> UNLOAD, cnt=0.
- wd==TIMEOUT-1 without done -> err_timeout=1, state LOAD, cnt=0.
REQ-025 fft_done SHALL be ignored outside COMPUTE.
REQ-026 fft_done in the same cycle as wd==TIMEOUT-1 SHALL take priority (go to UNLOAD, no error).
REQ-027 UNLOAD behaviour:
- rf_sel=1, rf_raddr=cnt (natural order), out_valid=1.
- out_data=rf_rdata, out_last=(cnt==7).
- On out_valid&&out_ready: cnt++; after the 8th transfer -> LOAD, cnt=0.
REQ-028 out_valid SHALL stay high, and out_data/out_last stable, while out_ready=0 (no drop, no advance).
REQ-029 Output defaults (outside the state that drives them):
- in_ready=0, rf_we=0, fft_start=0, out_valid=0, out_last=0.
- rf_waddr=0, rf_raddr=0, rf_wdata=0.
REQ-030 err_timeout SHALL clear only on rst; new frames SHALL be accepted while it is set.
REQ-031 cnt SHALL be 3 bits and wrap naturally; wd SHALL be $clog2(TIMEOUT)+1 bits.
REQ-032 Frame latency SHALL be:
- last input accept -> fft_start: 1 cycle;
- fft_done -> first out_valid: 1 cycle.

Reset
REQ-033 rst SHALL asynchronously force state=LOAD, cnt=0, wd=0, err_timeout=0.
REQ-034 All combinational outputs SHALL reflect the LOAD/cnt=0 state during reset.
REQ-035 Reset mid-frame SHALL discard the partial frame; the first input after reset lands at rf_waddr 0.

Structure
REQ-036 The shared package SHALL hold the state encoding localparams and the bitrev3 function (also used by testbenches).
REQ-037 Single module; no sub-module; the register file and FFT core stay external.

Verification
REQ-038 Load inputs 0..7 with in_valid held high:
- rf_waddr sequence is 0,4,2,6,1,5,3,7;
- fft_start pulses 1 cycle after the 8th accept.
REQ-039 Return fft_done 14 cycles after start, with out_ready=1:
- 8 consecutive outputs at raddr 0..7;
- out_last only on the 8th.
REQ-040 Toggle out_ready 1,0,0,1 during UNLOAD: out_data holds while stalled; exactly 8 transfers.
REQ-041 Never assert fft_done with TIMEOUT=32: err_timeout rises at cycle 32 of COMPUTE and the state returns to LOAD.
REQ-042 Assert fft_done exactly on wd==31: UNLOAD is entered and err_timeout stays 0.
REQ-043 Assert rst after 5 input accepts: in_ready=1 immediately; the next accept writes rf_waddr 0.
